branch_resolution_unit: RTL and testbench
=========================================

# branch_resolution_unit

Execute-side counterpart of the branch predictor. It records every prediction that fetch makes in an in-order queue. When execute resolves a branch, it checks the actual outcome against the oldest queued prediction and drives the predictor's update port (index, taken, target). On a mispredict it raises a one-cycle flush with the correct redirect PC and discards all younger wrong-path predictions.

## Interface
Parameters:
- LOWER, 5, width of the predictor index (table has 2**LOWER entries)
- DEPTH, 4, in-flight prediction queue entries; must be a power of two, at least 2
- PC_W, 64, PC and target width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- arst  in  1  asynchronous, active-high reset
- pred_valid  in  1  fetch issued a prediction for a branch this cycle
- pred_index  in  LOWER  predictor index used for that prediction
- pred_taken  in  1  predicted direction
- pred_target  in  PC_W  predicted target; don't-care when pred_taken=0
- pred_ready  out  1  queue can accept a push (not full)
- res_valid  in  1  execute resolved the oldest in-flight branch
- res_taken  in  1  actual direction
- res_target  in  PC_W  actual taken target
- res_fallthrough  in  PC_W  sequential PC of the branch (pc+4)
- upd_en  out  1  predictor update strobe
- upd_index  out  LOWER  index to update (the predictor's write address)
- upd_taken  out  1  actual outcome (the predictor's was_taken)
- upd_target  out  PC_W  actual target, written into the target field
- flush  out  1  one-cycle pipeline flush on mispredict
- redirect_pc  out  PC_W  correct fetch PC; valid only while flush=1
- mispredict_count  out  32  saturating mispredict counter
- underflow_err  out  1  sticky: res_valid arrived with the queue empty

## Operation
- The queue is circular, DEPTH entries, and each entry holds {index, taken, target}.
  - Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty.
  - pred_ready = !full, combinational from the pointers.
- Push when pred_valid && pred_ready && !flush.
- Pop when res_valid && !empty && !flush.
- Push and pop in the same cycle are both performed, so the occupancy is unchanged.
- Mispredict condition, evaluated on the popped head entry:
  - the directions differ (head.taken != res_taken), or
  - both directions are taken and the targets differ (head.target != res_target).
- On every pop, the following are registered at the next edge:
  - upd_en=1, upd_index=head.index, upd_taken=res_taken, upd_target=res_target.
- On a pop that mispredicts, additionally at the same edge:
  - flush=1;
  - redirect_pc = res_taken ? res_target : res_fallthrough;
  - both pointers reset to 0 (queue emptied, any same-cycle push discarded);
  - mispredict_count increments, saturating at 32'hFFFF_FFFF.
- upd_en and flush are single-cycle pulses; they return to 0 on the next edge unless another pop occurs.
- Wrong-path shadow: while flush=1, all pred_valid and res_valid inputs are ignored. Pushes are dropped and no pop, update or underflow check takes place.
- res_valid with the queue empty (and flush=0):
  - underflow_err is set to 1;
  - no update and no flush are issued;
  - underflow_err clears only on reset.
- Reset (arst=1, takes effect immediately):
  - queue empty, pred_ready=1;
  - upd_en=0, upd_index=0, upd_taken=0, upd_target=0;
  - flush=0, redirect_pc=0;
  - mispredict_count=0, underflow_err=0.

## Timing
- Resolution to update/flush latency: 1 cycle. Outputs are registered and valid in the cycle after res_valid is sampled.
- Push to visible-at-head latency: 1 cycle. An entry pushed at edge N can be popped by a res_valid sampled at edge N+1.
- Full queue: pred_ready=0. This holds even if a pop occurs in the same cycle (no bypass); fetch must stall.
- Throughput: 1 resolution per cycle, except in the cycle after a mispredict (flush shadow).
- Reset asserted mid-operation: the queue is cleared asynchronously and any pending upd_en/flush pulse is aborted.
- After reset deasserts, operation resumes on the first rising edge.

## Structure
- Shared package bru_pkg:
  - pred_entry_t struct {index, taken, target};
  - function is_mispredict(entry, taken, target);
  - localparam CNT_MAX = 32'hFFFF_FFFF.
- Sub-module pred_fifo implements the circular queue:
  - ports: push, pop, clear, din, dout (head), full, empty;
  - clear has priority over push.
- The top level holds the compare logic, output registers, counter and sticky error.

## Test plan
- Reset, then push {idx=3, taken=1, tgt=0x100}, then resolve taken with tgt=0x100 → next cycle upd_en=1, upd_index=3, upd_taken=1, flush=0, count=0.
- Push {idx=5, taken=0}, then resolve taken with tgt=0x200, fallthrough 0x44 → flush=1, redirect_pc=0x200, count=1. The queue is empty afterwards even when 2 pushes were pending.
- Push {idx=7, taken=1, tgt=0x300}, then resolve taken with tgt=0x304 → flush=1, redirect_pc=0x304, upd_target=0x304.
- Push 4 entries with DEPTH=4 → pred_ready=0. A push while full is dropped; after 1 pop, pred_ready=1 and FIFO order is preserved across pointer wrap (8 push/pop pairs).
- Assert res_valid with the queue empty → underflow_err=1 and stays 1, upd_en stays 0. A res_valid and pred_valid during the flush cycle are both ignored.
- Assert arst while upd_en=1 and the queue is half full → all outputs 0 immediately, pred_ready=1. Preload mispredict_count near its maximum and force extra mispredicts → it holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types and helpers for the branch resolution unit.
// Entries are sized for the widest supported index and PC.
package bru_pkg;

   localparam int IDX_MAX = 16;
   localparam int PC_MAX = 64;
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [IDX_MAX-1:0] index;
      logic               taken;
      logic [PC_MAX-1:0]  target;
   } pred_entry_t;

   // Targets only matter when both sides agree the branch is taken.
   function automatic logic is_mispredict(
      input pred_entry_t       entry,
      input logic              taken,
      input logic [PC_MAX-1:0] target
   );
      return (entry.taken != taken) ||
             (taken && (entry.target != target));
   endfunction

endpackage

// File: rtl/pred_fifo.sv
// Circular in-order queue of outstanding branch predictions.
// Pointers carry an extra wrap bit to tell full from empty.
module pred_fifo
   import bru_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        push,
   input  logic        pop,
   input  logic        clear,
   input  pred_entry_t din,
   output pred_entry_t dout,
   output logic        full,
   output logic        empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;
   pred_entry_t mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout = mem[rd_ptr[AW-1:0]];

   assign do_push = push && !full && !clear;
   assign do_pop = pop && !empty && !clear;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/branch_resolution_unit.sv
// Checks resolved branches against queued predictions, drives
// predictor updates and raises a one-cycle flush on mispredict.
module branch_resolution_unit
   import bru_pkg::*;
#(
   parameter int LOWER = 5,
   parameter int DEPTH = 4,
   parameter int PC_W = 64
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             pred_valid,
   input  logic [LOWER-1:0] pred_index,
   input  logic             pred_taken,
   input  logic [PC_W-1:0]  pred_target,
   output logic             pred_ready,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic [PC_W-1:0]  res_target,
   input  logic [PC_W-1:0]  res_fallthrough,
   output logic             upd_en,
   output logic [LOWER-1:0] upd_index,
   output logic             upd_taken,
   output logic [PC_W-1:0]  upd_target,
   output logic             flush,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [31:0]      mispredict_count,
   output logic             underflow_err
);

   pred_entry_t       din;
   pred_entry_t       head;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              mis;
   logic [PC_MAX-1:0] res_target_x;
   logic              unused_head;

   assign din.index = IDX_MAX'(pred_index);
   assign din.taken = pred_taken;
   assign din.target = PC_MAX'(pred_target);
   assign res_target_x = PC_MAX'(res_target);
   assign unused_head = ^head.index;

   assign pred_ready = !full;
   // Both inputs are wrong-path while the flush pulse is high.
   assign push = pred_valid && !full && !flush;
   assign pop = res_valid && !empty && !flush;
   assign mis = pop && is_mispredict(head, res_taken, res_target_x);

   pred_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (clk),
      .arst (arst),
      .push (push),
      .pop  (pop),
      .clear(mis),
      .din  (din),
      .dout (head),
      .full (full),
      .empty(empty)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         upd_en <= 1'b0;
         upd_index <= '0;
         upd_taken <= 1'b0;
         upd_target <= '0;
         flush <= 1'b0;
         redirect_pc <= '0;
         mispredict_count <= '0;
         underflow_err <= 1'b0;
      end else begin
         upd_en <= pop;
         flush <= mis;
         if (pop) begin
            upd_index <= head.index[LOWER-1:0];
            upd_taken <= res_taken;
            upd_target <= res_target;
         end
         if (mis) begin
            redirect_pc <= res_taken ? res_target : res_fallthrough;
            if (mispredict_count != CNT_MAX)
               mispredict_count <= mispredict_count + 32'd1;
         end
         if (res_valid && empty && !flush) underflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Randomised scoreboard bench for branch_resolution_unit against
// a queue-based model of the prediction/resolution rules.
module tb_branch_resolution_unit;

   localparam int LOWER = 5;
   localparam int DEPTH = 4;
   localparam int PC_W = 64;

   logic             clk = 1'b0;
   logic             arst;
   logic             pred_valid;
   logic [LOWER-1:0] pred_index;
   logic             pred_taken;
   logic [PC_W-1:0]  pred_target;
   logic             pred_ready;
   logic             res_valid;
   logic             res_taken;
   logic [PC_W-1:0]  res_target;
   logic [PC_W-1:0]  res_fallthrough;
   logic             upd_en;
   logic [LOWER-1:0] upd_index;
   logic             upd_taken;
   logic [PC_W-1:0]  upd_target;
   logic             flush;
   logic [PC_W-1:0]  redirect_pc;
   logic [31:0]      mispredict_count;
   logic             underflow_err;

   always #5 clk = ~clk;

   branch_resolution_unit #(
      .LOWER(LOWER),
      .DEPTH(DEPTH),
      .PC_W (PC_W)
   ) dut (
      .clk             (clk),
      .arst            (arst),
      .pred_valid      (pred_valid),
      .pred_index      (pred_index),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .pred_ready      (pred_ready),
      .res_valid       (res_valid),
      .res_taken       (res_taken),
      .res_target      (res_target),
      .res_fallthrough (res_fallthrough),
      .upd_en          (upd_en),
      .upd_index       (upd_index),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .flush           (flush),
      .redirect_pc     (redirect_pc),
      .mispredict_count(mispredict_count),
      .underflow_err   (underflow_err)
   );

   typedef struct {
      logic [LOWER-1:0] idx;
      bit               tk;
      logic [PC_W-1:0]  tg;
   } ent_t;

   typedef struct {
      logic [LOWER-1:0] idx;
      bit               tk;
      logic [PC_W-1:0]  tg;
      bit               mis;
      logic [PC_W-1:0]  rd;
   } exp_t;

   ent_t        mq[$];
   exp_t        sb[$];
   bit          flush_m;
   bit          uf_m;
   logic [31:0] cnt_m;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   // Monitor: every update pulse must match the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (upd_en) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_update: got upd_en=1 expected 0");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("upd_index", 64'(upd_index), 64'(e.idx));
            check("upd_taken", 64'(upd_taken), 64'(e.tk));
            check("upd_target", upd_target, e.tg);
            check("flush", 64'(flush), 64'(e.mis));
            if (e.mis) check("redirect_pc", redirect_pc, e.rd);
         end
      end else begin
         check("flush_alone", 64'(flush), 64'd0);
      end
   end

   task automatic issue(input bit pv, input logic [LOWER-1:0] pi,
                        input bit pt, input logic [63:0] ptg,
                        input bit rv, input bit rt,
                        input logic [63:0] rtg, input logic [63:0] rft);
      bit   rdy;
      bit   mis;
      bit   popm;
      ent_t h;
      rdy = (mq.size() < DEPTH);
      check("pred_ready", 64'(pred_ready), 64'(rdy));
      check("underflow_err", 64'(underflow_err), 64'(uf_m));
      check("mispredict_count", 64'(mispredict_count), 64'(cnt_m));
      pred_valid = pv;
      pred_index = pi;
      pred_taken = pt;
      pred_target = ptg;
      res_valid = rv;
      res_taken = rt;
      res_target = rtg;
      res_fallthrough = rft;
      popm = 1'b0;
      mis = 1'b0;
      if (!flush_m) begin
         if (rv && mq.size() > 0) begin
            h = mq.pop_front();
            popm = 1'b1;
            mis = (h.tk != rt) || (rt && h.tg != rtg);
            sb.push_back('{h.idx, rt, rtg, mis, rt ? rtg : rft});
            if (mis) begin
               mq.delete();
               if (cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
            end
         end else if (rv) begin
            uf_m = 1'b1;
         end
         if (pv && rdy && !mis) mq.push_back('{pi, pt, ptg});
      end
      flush_m = mis;
      @(posedge clk);
      @(negedge clk);
      pred_valid = 1'b0;
      res_valid = 1'b0;
      if (popm) check("update_latency", 64'(sb.size()), 64'd0);
   endtask

   task automatic idle();
      issue(1'b0, '0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
   endtask

   task automatic push_only(input logic [LOWER-1:0] pi, input bit pt,
                            input logic [63:0] ptg);
      issue(1'b1, pi, pt, ptg, 1'b0, 1'b0, 64'd0, 64'd0);
   endtask

   // Resolve the head exactly as predicted (never a mispredict).
   task automatic pop_good(input bit pv, input logic [LOWER-1:0] pi,
                           input logic [63:0] ptg);
      issue(pv, pi, 1'b1, ptg, 1'b1, mq[0].tk, mq[0].tg, r64());
   endtask

   task automatic rand_step();
      bit               pv;
      bit               rv;
      bit               rt;
      logic [63:0]      rtg;
      logic [LOWER-1:0] pi;
      pv = ($urandom % 3) != 0;
      rv = ($urandom % 2) != 0;
      pi = LOWER'($urandom);
      rt = ($urandom % 2) != 0;
      rtg = r64();
      if (mq.size() > 0) begin
         rt = (($urandom % 5) == 0) ? !mq[0].tk : mq[0].tk;
         if ($urandom % 4 != 0) rtg = mq[0].tg;
      end
      issue(pv, pi, ($urandom % 2) != 0, r64(), rv, rt, rtg, r64());
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      arst = 1'b1;
      pred_valid = 1'b0;
      pred_index = '0;
      pred_taken = 1'b0;
      pred_target = '0;
      res_valid = 1'b0;
      res_taken = 1'b0;
      res_target = '0;
      res_fallthrough = '0;
      flush_m = 1'b0;
      uf_m = 1'b0;
      cnt_m = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_pred_ready", 64'(pred_ready), 64'd1);
      check("rst_upd_en", 64'(upd_en), 64'd0);
      check("rst_upd_index", 64'(upd_index), 64'd0);
      check("rst_upd_taken", 64'(upd_taken), 64'd0);
      check("rst_upd_target", upd_target, 64'd0);
      check("rst_flush", 64'(flush), 64'd0);
      check("rst_redirect", redirect_pc, 64'd0);
      check("rst_count", 64'(mispredict_count), 64'd0);
      check("rst_underflow", 64'(underflow_err), 64'd0);
      arst = 1'b0;
      @(negedge clk);

      // Correct taken prediction.
      push_only(5'd3, 1'b1, 64'h100);
      issue(1'b0, '0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h100, 64'h44);
      check("t1_upd_en", 64'(upd_en), 64'd1);
      check("t1_upd_index", 64'(upd_index), 64'd3);
      check("t1_flush", 64'(flush), 64'd0);
      idle();

      // Direction mispredict with pushes pending and one in flight.
      push_only(5'd5, 1'b0, 64'd0);
      push_only(5'd9, 1'b1, 64'h500);
      issue(1'b1, 5'd10, 1'b1, 64'h600, 1'b1, 1'b1, 64'h200, 64'h44);
      check("t2_flush", 64'(flush), 64'd1);
      check("t2_redirect", redirect_pc, 64'h200);
      issue(1'b1, 5'd11, 1'b1, 64'h700, 1'b1, 1'b1, 64'h700, 64'h48);
      idle();

      // Target mispredict.
      push_only(5'd7, 1'b1, 64'h300);
      issue(1'b0, '0, 1'b0, 64'd0, 1'b1, 1'b1, 64'h304, 64'h7c);
      check("t3_flush", 64'(flush), 64'd1);
      check("t3_redirect", redirect_pc, 64'h304);
      check("t3_upd_target", upd_target, 64'h304);
      idle();

      // Fill, drop when full, then wrap the pointers.
      for (int i = 0; i < DEPTH + 1; i++)
         push_only(LOWER'(i), 1'b1, 64'h1000 + 64'(i * 4));
      check("t4_full", 64'(pred_ready), 64'd0);
      pop_good(1'b1, 5'd30, 64'h2000);
      for (int i = 0; i < 8; i++)
         pop_good(1'b1, LOWER'(16 + i), 64'h3000 + 64'(i * 8));
      while (mq.size() > 0) pop_good(1'b0, '0, 64'd0);
      idle();

      // Underflow is sticky and produces no update.
      issue(1'b0, '0, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 64'h4);
      check("t5_upd_en", 64'(upd_en), 64'd0);
      idle();
      idle();

      repeat (2000) rand_step();
      while (mq.size() > 0) pop_good(1'b0, '0, 64'd0);
      idle();
      idle();

      // Asynchronous reset during an update with entries queued.
      for (int i = 0; i < 3; i++) push_only(LOWER'(i + 1), 1'b1, r64());
      pop_good(1'b0, '0, 64'd0);
      check("t6_upd_before_rst", 64'(upd_en), 64'd1);
      arst = 1'b1;
      #1;
      check("t6_upd_en", 64'(upd_en), 64'd0);
      check("t6_flush", 64'(flush), 64'd0);
      check("t6_pred_ready", 64'(pred_ready), 64'd1);
      check("t6_count", 64'(mispredict_count), 64'd0);
      check("t6_underflow", 64'(underflow_err), 64'd0);
      check("t6_upd_target", upd_target, 64'd0);
      mq.delete();
      flush_m = 1'b0;
      uf_m = 1'b0;
      cnt_m = 32'd0;
      arst = 1'b0;
      @(negedge clk);

      // Saturation of the mispredict counter.
      force dut.mispredict_count = 32'hFFFF_FFFD;
      #1;
      release dut.mispredict_count;
      cnt_m = 32'hFFFF_FFFD;
      repeat (4) begin
         push_only(5'd2, 1'b0, 64'd0);
         issue(1'b0, '0, 1'b0, 64'd0, 1'b1, 1'b1, r64(), r64());
         idle();
      end
      check("t7_saturated", 64'(mispredict_count), 64'hFFFF_FFFF);
      idle();

      check("sb_leftover", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
